mmio_io_ctrl: RTL
=================

// Module: mmio_io_ctrl
// PURPOSE
//  Parametrised memory-mapped I/O controller between the CPU memory bus and board I/O.
//  - Switch input: synchronised, optionally debounced, readable.
//  - LED output: register, writable and readable back.
//  - Sticky switch-change status flag, cleared when the status register is read.
//  - Drives read_data/read_en so the top level can mux I/O reads against RAM.
// PARAMETERS
//  ADDR_W     9       bus address width
//  DATA_W     16      bus data width
//  SW_W       8       switch input width (<= DATA_W)
//  LED_W      8       LED output width (<= DATA_W)
//  SW_ADDR    9'h140  switch data register address (read-only)
//  STAT_ADDR  9'h141  status register address (read, clear-on-read)
//  LED_ADDR   9'h100  LED register address (read/write)
//  DB_CYCLES  16      debounce stability count; used only with MMIO_DEBOUNCE_EN
// PORTS
//  clk         in   1       system clock, rising edge
//  reset       in   1       asynchronous, active-high
//  mem_cmd     in   2       00 MNONE, 01 MREAD, 10 MWRITE, 11 treated as MNONE
//  mem_addr    in   ADDR_W  bus address
//  write_data  in   DATA_W  bus write data
//  SW          in   SW_W    raw asynchronous switch inputs
//  read_data   out  DATA_W  I/O read data, zero-extended; 0 when read_en=0
//  read_en     out  1       high when this block owns the current read
//  LEDR        out  LED_W   LED register
//  sw_changed  out  1       sticky change flag (also status bit0)
// BEHAVIOUR
//  Reset values (async): sync stages=0, sw_val=0, sw_prev=0, LEDR=0, sw_changed=0, debounce counter=0.
//  Synchroniser: two flops on SW -> sw_s. sw_s reflects SW 2 cycles after an SW change.
//  sw_val:
//   - Without debounce: sw_val <= sw_s every cycle.
//   - With debounce: see CONFIGURATION.
//  Change detect: sw_prev <= sw_val every cycle.
//   - sw_changed sets on the edge after sw_val != sw_prev.
//  Read decode (combinational, same cycle as the MREAD):
//   - read_en = (mem_cmd==MREAD) && addr in {SW_ADDR, STAT_ADDR, LED_ADDR}.
//   - SW_ADDR -> {0, sw_val}.
//   - STAT_ADDR -> {0, db_busy, sw_changed}; db_busy is bit1 and is constant 0 without debounce.
//   - LED_ADDR -> {0, LEDR}.
//  Clear-on-read:
//   - A clock edge with MREAD to STAT_ADDR clears sw_changed.
//   - The read returns the pre-clear value.
//   - If a new change is detected on the same edge, set wins: sw_changed stays 1.
//  LED write: clock edge with MWRITE and addr==LED_ADDR -> LEDR <= write_data[LED_W-1:0].
//  Ignored accesses, with no state change and read_en=0:
//   - MWRITE to SW_ADDR or STAT_ADDR.
//   - Any command to an unmapped address.
//   - MNONE or 11.
//  Reset mid-operation: all state returns to reset values immediately; a pending debounce count is lost.
//  Elaboration checks: SW_W<=DATA_W, LED_W<=DATA_W, the three addresses distinct, DB_CYCLES>=1.
// CONFIGURATION
//  Macro MMIO_DEBOUNCE_EN.
//  Defined:
//   - Counter width is $clog2(DB_CYCLES+1).
//   - Counter resets to 0 whenever sw_s != candidate; candidate <= sw_s.
//   - Otherwise the counter increments, saturating.
//   - When the count reaches DB_CYCLES, sw_val <= candidate.
//   - db_busy = (sw_s != sw_val).
//  Undefined:
//   - No counter logic; sw_val follows sw_s with one extra cycle; db_busy=0.
// TESTING
//  1. Assert reset mid-run with LEDR=8'hA5 -> LEDR=0, sw_changed=0, read_data=0 immediately.
//  2. MWRITE 16'h12C3 to 9'h100, then MREAD 9'h100 -> LEDR=8'hC3, read_en=1, read_data=16'h00C3.
//  3. No debounce: SW 00->8'h5A -> MREAD 9'h140 returns 16'h005A from the 3rd edge on; sw_changed=1 one edge later.
//  4. MREAD 9'h141 with flag set -> data 16'h0001, flag 0 next cycle; with a change arriving on that edge, flag stays 1.
//  5. MWRITE to 9'h140, MREAD 9'h0FF, mem_cmd=11 -> read_en=0, read_data=0, LEDR unchanged.
//  6. MMIO_DEBOUNCE_EN, DB_CYCLES=4: SW toggles every 2 cycles, then holds 8'h0F -> sw_val unchanged until 4 stable cycles after sync; bit1=1 meanwhile.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped I/O controller: synchronised switch input, LED register, sticky change flag.
// Latency: reads are combinational in the MREAD cycle; SW reaches the read path 3 edges after a change.
// Backpressure: none; every bus command is accepted in its own cycle. Optional debounce: MMIO_DEBOUNCE_EN.
module mmio_io_ctrl #(
    parameter int              ADDR_W    = 9,
    parameter int              DATA_W    = 16,
    parameter int              SW_W      = 8,
    parameter int              LED_W     = 8,
    parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140,
    parameter logic [ADDR_W-1:0] STAT_ADDR = 9'h141,
    parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
    parameter int              DB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [SW_W-1:0]   SW,
    output logic [DATA_W-1:0] read_data,
    output logic              read_en,
    output logic [LED_W-1:0]  LEDR,
    output logic              sw_changed
);

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    // Parameter sanity: bad configurations stop elaboration.
    if (SW_W > DATA_W) begin : g_chk_sw_w
        $error("mmio_io_ctrl: SW_W must not exceed DATA_W");
    end
    if (LED_W > DATA_W) begin : g_chk_led_w
        $error("mmio_io_ctrl: LED_W must not exceed DATA_W");
    end
    if (SW_ADDR == STAT_ADDR || SW_ADDR == LED_ADDR || STAT_ADDR == LED_ADDR) begin : g_chk_addr
        $error("mmio_io_ctrl: register addresses must be distinct");
    end
    if (DB_CYCLES < 1) begin : g_chk_db
        $error("mmio_io_ctrl: DB_CYCLES must be at least 1");
    end

    // Write data above the LED field is never stored.
    if (LED_W < DATA_W) begin : g_wd_hi
        logic unused_wd_hi;
        assign unused_wd_hi = ^write_data[DATA_W-1:LED_W];
    end

    logic [SW_W-1:0]  sync1_q, sync1_d;
    logic [SW_W-1:0]  sw_s_q, sw_s_d;
    logic [SW_W-1:0]  sw_val_q, sw_val_d;
    logic [SW_W-1:0]  sw_prev_q, sw_prev_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             sw_changed_q, sw_changed_d;
    logic             db_busy;

    logic is_rd, is_wr, hit_sw, hit_stat, hit_led, stat_rd;

    assign is_rd    = (mem_cmd == MREAD);
    assign is_wr    = (mem_cmd == MWRITE);
    assign hit_sw   = (mem_addr == SW_ADDR);
    assign hit_stat = (mem_addr == STAT_ADDR);
    assign hit_led  = (mem_addr == LED_ADDR);
    // Clear-on-read fires on the edge that completes a status read.
    assign stat_rd  = is_rd && hit_stat;

`ifdef MMIO_DEBOUNCE_EN
    localparam int               CNT_W   = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    logic [SW_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: restart the count whenever the synchronised input moves, publish once it held long enough.
    always_comb begin
        cand_d = sw_s_q;
        cnt_d  = cnt_q;
        if (sw_s_q != cand_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        sw_val_d = (cnt_q == CNT_MAX) ? cand_q : sw_val_q;
        db_busy  = (sw_s_q != sw_val_q);
    end

    // Debounce state; an in-flight count is dropped on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end
`else
    // Without debounce the published value is simply the synchroniser output one edge later.
    always_comb begin
        sw_val_d = sw_s_q;
        db_busy  = 1'b0;
    end
`endif

    // Next state for synchroniser, change detector, sticky flag and LED register.
    always_comb begin
        sync1_d   = SW;
        sw_s_d    = sync1_q;
        sw_prev_d = sw_val_q;
        // A change detected on the clearing edge wins over the clear.
        sw_changed_d = (sw_val_q != sw_prev_q) || (sw_changed_q && !stat_rd);
        led_d        = (is_wr && hit_led) ? write_data[LED_W-1:0] : led_q;
    end

    // State registers; everything returns to zero immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sw_s_q       <= '0;
            sw_val_q     <= '0;
            sw_prev_q    <= '0;
            led_q        <= '0;
            sw_changed_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sw_s_q       <= sw_s_d;
            sw_val_q     <= sw_val_d;
            sw_prev_q    <= sw_prev_d;
            led_q        <= led_d;
            sw_changed_q <= sw_changed_d;
        end
    end

    // Read decode: claims only mapped reads and returns zero whenever it does not own the read.
    always_comb begin
        read_en   = is_rd && (hit_sw || hit_stat || hit_led);
        read_data = '0;
        if (is_rd) begin
            if (hit_sw) begin
                read_data = DATA_W'(sw_val_q);
            end else if (hit_stat) begin
                read_data = DATA_W'({db_busy, sw_changed_q});
            end else if (hit_led) begin
                read_data = DATA_W'(led_q);
            end
        end
    end

    assign LEDR       = led_q;
    assign sw_changed = sw_changed_q;

endmodule
